// File: rtl/lvds_tx_framer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : lvds_pkg
// Description : Shared LVDS link states and default per-lane framing words.
// Revision    : 1.0
// ============================================================================
package lvds_pkg;

  typedef enum logic [2:0] {
    S_RST   = 3'd0,
    S_IDLE  = 3'd1,
    S_TRAIN = 3'd2,
    S_SYNC  = 3'd3,
    S_DATA  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_TRAIN = 2'd1,
    W_SYNC  = 2'd2,
    W_DATA  = 2'd3
  } word_sel_t;

  localparam int         c_SERI_FACTOR_DEFAULT = 10;
  localparam logic [9:0] c_TRAIN_PATTERN       = 10'b1110010100;
  localparam logic [9:0] c_SYNC_WORD           = 10'b0011111100;
  localparam logic [9:0] c_IDLE_WORD           = 10'b0000011111;

endpackage
`default_nettype wire

// File: rtl/lvds_tx_framer_if.sv
`default_nettype none
// ============================================================================
// Interface   : lvds_tx_framer_if
// Description : User word stream (valid/ready) into the LVDS TX framer.
// Revision    : 1.0
// ============================================================================
interface lvds_tx_framer_if #(
  parameter int LANES       = 4,
  parameter int SERI_FACTOR = 10
);

  logic [LANES*SERI_FACTOR-1:0] s_data;
  logic                         s_valid;
  logic                         s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );

endinterface
`default_nettype wire

// File: rtl/lvds_tx_framer_lane_mux.sv
`default_nettype none
// ============================================================================
// Module      : lvds_tx_lane_mux
// Description : Registers one lane's OSERDES word from a framer word select.
// Revision    : 1.0
// ============================================================================
module lvds_tx_lane_mux
  import lvds_pkg::*;
#(
  parameter int                     SERI_FACTOR   = c_SERI_FACTOR_DEFAULT,
  parameter logic [SERI_FACTOR-1:0] TRAIN_PATTERN = SERI_FACTOR'(c_TRAIN_PATTERN),
  parameter logic [SERI_FACTOR-1:0] SYNC_WORD     = SERI_FACTOR'(c_SYNC_WORD),
  parameter logic [SERI_FACTOR-1:0] IDLE_WORD     = SERI_FACTOR'(c_IDLE_WORD)
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  input  wire word_sel_t              sel,
  input  wire logic [SERI_FACTOR-1:0] data_in,
  output logic      [SERI_FACTOR-1:0] word_out
);

  logic [SERI_FACTOR-1:0] r_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= IDLE_WORD;
    end else begin
      case (sel)
        W_TRAIN: r_word <= TRAIN_PATTERN;
        W_SYNC:  r_word <= SYNC_WORD;
        W_DATA:  r_word <= data_in;
        default: r_word <= IDLE_WORD;
      endcase
    end
  end

  assign word_out = r_word;

endmodule
`default_nettype wire

// File: rtl/lvds_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : lvds_tx_framer
// Description : LVDS TX word framer: OSERDES reset sequencing, idle/training/
//               sync framing and valid/ready user word streaming.
// Revision    : 1.0
// ============================================================================
module lvds_tx_framer
  import lvds_pkg::*;
#(
  parameter int                     SERI_FACTOR   = c_SERI_FACTOR_DEFAULT,
  parameter int                     LANES         = 4,
  parameter int                     TRAIN_WORDS   = 256,
  parameter int                     RST_CYCLES    = 8,
  parameter logic [SERI_FACTOR-1:0] TRAIN_PATTERN = SERI_FACTOR'(c_TRAIN_PATTERN),
  parameter logic [SERI_FACTOR-1:0] SYNC_WORD     = SERI_FACTOR'(c_SYNC_WORD),
  parameter logic [SERI_FACTOR-1:0] IDLE_WORD     = SERI_FACTOR'(c_IDLE_WORD)
) (
  input  wire logic                         tx_clkdiv,
  input  wire logic                         reset_n,
  input  wire logic                         mmcm_locked,
  input  wire logic                         tx_en,
  input  wire logic                         retrain,
  lvds_tx_framer_if.slave                   s_if,
  output logic [LANES*SERI_FACTOR-1:0]      tx_data_out,
  output logic [SERI_FACTOR-1:0]            tx_clk_pattern,
  output logic                              oserdes_rst,
  output logic                              link_trained
);

  localparam int c_RST_CW   = $clog2(RST_CYCLES + 1);
  localparam int c_TRAIN_CW = $clog2(TRAIN_WORDS + 1);
  localparam logic [c_RST_CW-1:0]   c_RST_LAST   = c_RST_CW'(RST_CYCLES - 1);
  localparam logic [c_TRAIN_CW-1:0] c_TRAIN_LAST = c_TRAIN_CW'(TRAIN_WORDS - 1);

  state_t                r_state;
  state_t                w_next_state;
  logic [c_RST_CW-1:0]   r_rst_cnt;
  logic [c_RST_CW-1:0]   w_rst_cnt_nxt;
  logic [c_TRAIN_CW-1:0] r_train_cnt;
  logic [c_TRAIN_CW-1:0] w_train_cnt_nxt;
  logic                  r_oserdes_rst;
  logic                  r_link_trained;
  logic                  w_ready;
  logic                  w_accept;
  word_sel_t             w_sel;

  assign w_ready     = (r_state == S_DATA) & tx_en & mmcm_locked & ~retrain;
  assign w_accept    = w_ready & s_if.s_valid;
  assign s_if.s_ready = w_ready;

  always_ff @(posedge tx_clkdiv or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_RST;
      r_rst_cnt      <= '0;
      r_train_cnt    <= '0;
      r_oserdes_rst  <= 1'b1;
      r_link_trained <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_rst_cnt      <= w_rst_cnt_nxt;
      r_train_cnt    <= w_train_cnt_nxt;
      r_oserdes_rst  <= (w_next_state == S_RST);
      r_link_trained <= (w_next_state == S_DATA);
    end
  end

  // Counters default to zero so every state entry starts from a clean count.
  always_comb begin
    w_next_state    = r_state;
    w_rst_cnt_nxt   = '0;
    w_train_cnt_nxt = '0;
    if (!mmcm_locked) begin
      w_next_state = S_RST;
    end else begin
      case (r_state)
        S_RST: begin
          if (r_rst_cnt == c_RST_LAST) begin
            w_next_state = S_IDLE;
          end else begin
            w_rst_cnt_nxt = r_rst_cnt + c_RST_CW'(1);
          end
        end
        S_IDLE: begin
          if (tx_en) begin
            w_next_state = S_TRAIN;
          end
        end
        S_TRAIN: begin
          if (!tx_en) begin
            w_next_state = S_IDLE;
          end else if (r_train_cnt == c_TRAIN_LAST) begin
            w_next_state = S_SYNC;
          end else begin
            w_train_cnt_nxt = r_train_cnt + c_TRAIN_CW'(1);
          end
        end
        S_SYNC: begin
          w_next_state = tx_en ? S_DATA : S_IDLE;
        end
        S_DATA: begin
          if (!tx_en) begin
            w_next_state = S_IDLE;
          end else if (retrain) begin
            w_next_state = S_TRAIN;
          end
        end
        default: w_next_state = S_RST;
      endcase
    end
  end

  // The lane registers load the word belonging to the state being entered.
  always_comb begin
    w_sel = W_IDLE;
    case (w_next_state)
      S_TRAIN: w_sel = W_TRAIN;
      S_SYNC:  w_sel = W_SYNC;
      S_DATA:  w_sel = w_accept ? W_DATA : W_IDLE;
      default: w_sel = W_IDLE;
    endcase
  end

  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      lvds_tx_lane_mux #(
        .SERI_FACTOR   (SERI_FACTOR),
        .TRAIN_PATTERN (TRAIN_PATTERN),
        .SYNC_WORD     (SYNC_WORD),
        .IDLE_WORD     (IDLE_WORD)
      ) u_lane_mux (
        .clk      (tx_clkdiv),
        .rst_n    (reset_n),
        .sel      (w_sel),
        .data_in  (s_if.s_data[k*SERI_FACTOR +: SERI_FACTOR]),
        .word_out (tx_data_out[k*SERI_FACTOR +: SERI_FACTOR])
      );
    end
  endgenerate

  assign tx_clk_pattern = {{(SERI_FACTOR/2){1'b1}}, {(SERI_FACTOR/2){1'b0}}};
  assign oserdes_rst    = r_oserdes_rst;
  assign link_trained   = r_link_trained;

endmodule
`default_nettype wire

// File: tb/tb_lvds_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lvds_tx_framer
// Description : Self-checking bench for lvds_tx_framer (4 lanes x 10 bits).
// Revision    : 1.0
// ============================================================================
module tb_lvds_tx_framer;

  localparam logic [39:0] c_IDLE4  = {4{10'b0000011111}};
  localparam logic [39:0] c_TRAIN4 = {4{10'b1110010100}};
  localparam logic [39:0] c_SYNC4  = {4{10'b0011111100}};
  localparam logic [9:0]  c_CLKPAT = 10'b1111100000;
  localparam logic [39:0] c_HOLD   = 40'hABCDE12345;

  typedef struct {
    int          n;
    bit          lock;
    bit          en;
    bit          ret;
    bit          valid;
    logic [39:0] word;
    bit          rst;
    bit          trained;
    bit          ready;
  } row_t;

  logic        clk;
  logic        reset_n;
  logic        mmcm_locked;
  logic        tx_en;
  logic        retrain;
  logic [39:0] tx_data_out;
  logic [9:0]  tx_clk_pattern;
  logic        oserdes_rst;
  logic        link_trained;

  int n_pass  = 0;
  int n_total = 0;
  int seq     = 0;

  row_t tbl_bringup[$];
  row_t tbl_retrain[$];
  row_t tbl_relock[$];

  lvds_tx_framer_if #(.LANES(4), .SERI_FACTOR(10)) s_if ();

  lvds_tx_framer dut (
    .tx_clkdiv      (clk),
    .reset_n        (reset_n),
    .mmcm_locked    (mmcm_locked),
    .tx_en          (tx_en),
    .retrain        (retrain),
    .s_if           (s_if),
    .tx_data_out    (tx_data_out),
    .tx_clk_pattern (tx_clk_pattern),
    .oserdes_rst    (oserdes_rst),
    .link_trained   (link_trained)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic row_t mk(input int n, input bit lock, input bit en, input bit ret,
                              input bit valid, input logic [39:0] word, input bit rst,
                              input bit trained, input bit ready);
    row_t r;
    r.n = n; r.lock = lock; r.en = en; r.ret = ret; r.valid = valid;
    r.word = word; r.rst = rst; r.trained = trained; r.ready = ready;
    return r;
  endfunction

  // Called at posedge+1: drive inputs, check the state-derived outputs each cycle.
  task automatic run_row(input row_t r, input string tag);
    for (int i = 0; i < r.n; i++) begin
      mmcm_locked  = r.lock;
      tx_en        = r.en;
      retrain      = r.ret;
      s_if.s_valid = r.valid;
      s_if.s_data  = c_HOLD;
      #2;
      chk({tag, "_word"},    tx_data_out,          r.word);
      chk({tag, "_rst"},     40'(oserdes_rst),     40'(r.rst));
      chk({tag, "_trained"}, 40'(link_trained),    40'(r.trained));
      chk({tag, "_ready"},   40'(s_if.s_ready),    40'(r.ready));
      chk({tag, "_clkpat"},  40'(tx_clk_pattern),  40'(c_CLKPAT));
      @(posedge clk); #1;
    end
  endtask

  task automatic stream(input int nbeats);
    logic [39:0] sb[$];
    logic [39:0] d;
    logic [39:0] exp;
    int beats = 0;
    int cyc   = 0;
    while (beats < nbeats && cyc < 1000) begin
      cyc++;
      for (int k = 0; k < 4; k++) d[k*10 +: 10] = 10'(seq * 4 + k);
      s_if.s_valid = ($urandom_range(0, 3) != 0);
      s_if.s_data  = d;
      #2;
      chk("stream_ready", 40'(s_if.s_ready), 40'(1));
      if (s_if.s_valid && s_if.s_ready) begin
        sb.push_back(d);
        beats++;
        seq++;
      end else begin
        sb.push_back(c_IDLE4);
      end
      @(posedge clk); #1;
      exp = sb.pop_front();
      chk("stream_word", tx_data_out, exp);
    end
    if (beats < nbeats) chk("stream_beats", 40'(beats), 40'(nbeats));
    s_if.s_valid = 1'b0;
    @(posedge clk); #1;
    chk("stream_tail", tx_data_out, c_IDLE4);
  endtask

  initial begin
    tbl_bringup.push_back(mk(4,   0, 0, 0, 0, c_IDLE4,  1, 0, 0));
    tbl_bringup.push_back(mk(8,   1, 0, 0, 0, c_IDLE4,  1, 0, 0));
    tbl_bringup.push_back(mk(3,   1, 0, 0, 0, c_IDLE4,  0, 0, 0));
    tbl_bringup.push_back(mk(1,   1, 1, 0, 0, c_IDLE4,  0, 0, 0));
    tbl_bringup.push_back(mk(256, 1, 1, 0, 0, c_TRAIN4, 0, 0, 0));
    tbl_bringup.push_back(mk(1,   1, 1, 0, 0, c_SYNC4,  0, 0, 0));
    tbl_bringup.push_back(mk(1,   1, 1, 0, 0, c_IDLE4,  0, 1, 1));

    tbl_retrain.push_back(mk(1,   1, 1, 1, 1, c_IDLE4,  0, 1, 0));
    tbl_retrain.push_back(mk(100, 1, 1, 0, 1, c_TRAIN4, 0, 0, 0));
    tbl_retrain.push_back(mk(1,   1, 1, 1, 1, c_TRAIN4, 0, 0, 0));
    tbl_retrain.push_back(mk(155, 1, 1, 0, 1, c_TRAIN4, 0, 0, 0));
    tbl_retrain.push_back(mk(1,   1, 1, 0, 1, c_SYNC4,  0, 0, 0));
    tbl_retrain.push_back(mk(1,   1, 1, 0, 0, c_IDLE4,  0, 1, 1));

    tbl_relock.push_back(mk(1,   0, 1, 0, 0, c_IDLE4,  0, 1, 0));
    tbl_relock.push_back(mk(3,   0, 1, 0, 0, c_IDLE4,  1, 0, 0));
    tbl_relock.push_back(mk(8,   1, 1, 0, 0, c_IDLE4,  1, 0, 0));
    tbl_relock.push_back(mk(1,   1, 1, 0, 0, c_IDLE4,  0, 0, 0));
    tbl_relock.push_back(mk(50,  1, 1, 0, 0, c_TRAIN4, 0, 0, 0));
    tbl_relock.push_back(mk(1,   1, 0, 0, 0, c_TRAIN4, 0, 0, 0));
    tbl_relock.push_back(mk(2,   1, 0, 0, 0, c_IDLE4,  0, 0, 0));
    tbl_relock.push_back(mk(1,   1, 1, 0, 0, c_IDLE4,  0, 0, 0));
    tbl_relock.push_back(mk(256, 1, 1, 0, 0, c_TRAIN4, 0, 0, 0));
    tbl_relock.push_back(mk(1,   1, 1, 0, 0, c_SYNC4,  0, 0, 0));
    tbl_relock.push_back(mk(1,   1, 1, 0, 0, c_IDLE4,  0, 1, 1));

    reset_n      = 1'b0;
    mmcm_locked  = 1'b0;
    tx_en        = 1'b0;
    retrain      = 1'b0;
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_word",    tx_data_out,         c_IDLE4);
    chk("reset_rst",     40'(oserdes_rst),    40'(1));
    chk("reset_trained", 40'(link_trained),   40'(0));
    chk("reset_ready",   40'(s_if.s_ready),   40'(0));
    chk("reset_clkpat",  40'(tx_clk_pattern), 40'(c_CLKPAT));
    reset_n = 1'b1;

    foreach (tbl_bringup[i]) run_row(tbl_bringup[i], "bringup");
    stream(100);
    foreach (tbl_retrain[i]) run_row(tbl_retrain[i], "retrain");
    stream(20);
    foreach (tbl_relock[i]) run_row(tbl_relock[i], "relock");
    stream(10);

    // Put a non-idle word on the lanes, then pulse reset_n between edges.
    s_if.s_valid = 1'b1;
    s_if.s_data  = c_HOLD;
    #2;
    chk("pre_areset_ready", 40'(s_if.s_ready), 40'(1));
    @(posedge clk); #1;
    s_if.s_valid = 1'b0;
    chk("pre_areset_word", tx_data_out, c_HOLD);
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset_word",    tx_data_out,         c_IDLE4);
    chk("areset_rst",     40'(oserdes_rst),    40'(1));
    chk("areset_trained", 40'(link_trained),   40'(0));
    chk("areset_ready",   40'(s_if.s_ready),   40'(0));
    chk("areset_clkpat",  40'(tx_clk_pattern), 40'(c_CLKPAT));
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_areset_rst", 40'(oserdes_rst), 40'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
